// File: rtl/apb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_master : valid/ready request to APB SETUP/ACCESS initiator.          |
// | Optional APB_MASTER_TIMEOUT_EN ends a transfer after to_c wait cycles.   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module apb_master #(
  parameter int a_w  = 8,
  parameter int to_c = 16
) (
  input  logic           pclk,
  input  logic           presetn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [a_w-1:0] req_addr,
  input  logic           req_we,
  input  logic [31:0]    req_wdata,
  input  logic [3:0]     req_wstrb,
  output logic           resp_valid,
  output logic [31:0]    resp_rdata,
  output logic           resp_err,
  output logic [a_w-1:0] paddr,
  output logic           psel,
  output logic           penable,
  output logic           pwrite,
  output logic [31:0]    pwdata,
  output logic [3:0]     pstrb,
  input  logic [31:0]    prdata,
  input  logic           pready,
  input  logic           pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [a_w-1:0] paddr_q, paddr_d;
  logic           pwrite_q, pwrite_d;
  logic [31:0]    pwdata_q, pwdata_d;
  logic [3:0]     pstrb_q, pstrb_d;
  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;
  logic           tmo_hit;

  if (to_c < 1) begin : g_to_c_check
    $error("apb_master: to_c must be >= 1");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(to_c + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero in IDLE so every SETUP starts with a fresh count.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (state_q == ACCESS && !pready) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit = (state_q == ACCESS) && !pready && (tmo_cnt_q == CW'(to_c - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = SETUP;
          paddr_d  = req_addr;
          pwrite_d = req_we;
          pwdata_d = req_wdata;
          pstrb_d  = req_we ? req_wstrb : 4'b0000;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over a timeout reached on the same cycle.
        if (pready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = pwrite_q ? 32'h0 : prdata;
          resp_err_d   = pslverr;
        end else if (tmo_hit) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= 32'h0;
      pstrb_q      <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign psel       = (state_q != IDLE);
  assign penable    = (state_q == ACCESS);
  assign paddr      = paddr_q;
  assign pwrite     = pwrite_q;
  assign pwdata     = pwdata_q;
  assign pstrb      = pstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apb_master : directed bench; expected outputs kept as a per-cycle     |
// | timeline filled from each transfer's handshake cycle and wait count.     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_apb_master;
  localparam int A_W  = 8;
  localparam int TO_C = 4;
  localparam int MAXC = 1024;

  logic           pclk = 1'b0;
  logic           presetn;
  logic           req_valid;
  logic           req_ready;
  logic [A_W-1:0] req_addr;
  logic           req_we;
  logic [31:0]    req_wdata;
  logic [3:0]     req_wstrb;
  logic           resp_valid;
  logic [31:0]    resp_rdata;
  logic           resp_err;
  logic [A_W-1:0] paddr;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [31:0]    pwdata;
  logic [3:0]     pstrb;
  logic [31:0]    prdata;
  logic           pready;
  logic           pslverr;

  apb_master #(.a_w(A_W), .to_c(TO_C)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  logic           e_psel [MAXC];
  logic           e_pen  [MAXC];
  logic           e_rdy  [MAXC];
  logic           e_rv   [MAXC];
  logic [A_W-1:0] e_addr [MAXC];
  logic           e_wr   [MAXC];
  logic [31:0]    e_wdata[MAXC];
  logic [3:0]     e_strb [MAXC];
  logic [31:0]    e_rdata[MAXC];
  logic           e_err  [MAXC];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Everything after cycle r reflects the reset state.
  task automatic model_reset(input int r);
    for (int c = r + 1; c < MAXC; c++) begin
      e_psel[c] = 1'b0; e_pen[c] = 1'b0; e_rdy[c] = 1'b1; e_rv[c] = 1'b0;
      e_addr[c] = '0; e_wr[c] = 1'b0; e_wdata[c] = 32'h0; e_strb[c] = 4'h0;
      e_rdata[c] = 32'h0; e_err[c] = 1'b0;
    end
  endtask

  // Handshake at h, w wait states: bus busy h+1..h+2+w, response at h+3+w.
  task automatic model_xfer(input int h, input int w, input logic [A_W-1:0] a,
                            input logic we, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] rd, input logic er, input logic tmo);
    int r;
    r = h + 3 + w;
    for (int c = h + 1; c < MAXC; c++) begin
      if (c < r) begin
        e_psel[c] = 1'b1; e_rdy[c] = 1'b0; e_pen[c] = (c >= h + 2);
      end
      e_addr[c] = a; e_wr[c] = we; e_wdata[c] = wd; e_strb[c] = we ? ws : 4'h0;
      if (c == r) e_rv[c] = 1'b1;
      if (c >= r) begin
        e_rdata[c] = (we || tmo) ? 32'h0 : rd;
        e_err[c]   = er || tmo;
      end
    end
  endtask

  always @(negedge pclk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("req_ready",  32'(req_ready),  32'(e_rdy[cyc]));
      chk("psel",       32'(psel),       32'(e_psel[cyc]));
      chk("penable",    32'(penable),    32'(e_pen[cyc]));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv[cyc]));
      chk("paddr",      32'(paddr),      32'(e_addr[cyc]));
      chk("pwrite",     32'(pwrite),     32'(e_wr[cyc]));
      chk("pwdata",     pwdata,          e_wdata[cyc]);
      chk("pstrb",      32'(pstrb),      32'(e_strb[cyc]));
      chk("resp_rdata", resp_rdata,      e_rdata[cyc]);
      chk("resp_err",   32'(resp_err),   32'(e_err[cyc]));
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_req(input logic [A_W-1:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] ws);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_wstrb = ws;
  endtask

  // Request fields are scrambled after the handshake; SETUP sees a bogus pready.
  task automatic post_handshake(input logic keep);
    req_valid = keep;
    req_addr  = A_W'($urandom);
    req_we    = 1'($urandom);
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    pready = 1'b1; pslverr = 1'b1; prdata = $urandom;
  endtask

  task automatic do_xfer(input logic [A_W-1:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, input int w, input logic [31:0] rd,
                         input logic er, input logic tmo, input logic keep);
    int h;
    h = cyc;
    drive_req(a, we, wd, ws);
    model_xfer(h, w, a, we, wd, ws, rd, er, tmo);
    step();
    post_handshake(keep);
    step();
    for (int k = 0; k <= w; k++) begin
      pready  = !tmo && (k == w);
      prdata  = (k == w) ? rd : $urandom;
      pslverr = (k == w) ? er : 1'($urandom);
      step();
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
  endtask

  // Stalls in ACCESS for n extra cycles, then pulses presetn for one cycle.
  task automatic do_abort(input logic [A_W-1:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] ws, input int n);
    int h;
    h = cyc;
    drive_req(a, we, wd, ws);
    model_xfer(h, 100000, a, we, wd, ws, 32'h0, 1'b0, 1'b0);
    step();
    post_handshake(1'b0);
    step();
    pready = 1'b0; pslverr = 1'b0;
    for (int k = 0; k < n; k++) step();
    chk("abort_psel_before", 32'(psel), 32'h1);
    chk("abort_rv_before", 32'(resp_valid), 32'h0);
    presetn = 1'b0;
    model_reset(cyc);
    step();
    presetn = 1'b1;
  endtask

  initial begin
    model_reset(0);
    presetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wdata = 32'h0; req_wstrb = 4'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    step(); step();
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rdata", resp_rdata, 32'h0);
    presetn = 1'b1;
    step();

    do_xfer(8'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_resp_valid", 32'(resp_valid), 32'h1);
    chk("t1_resp_err", 32'(resp_err), 32'h0);
    chk("t1_pwdata_held", pwdata, 32'hDEADBEEF);
    step();

    do_xfer(8'h24, 1'b0, 32'hCAFEF00D, 4'hF, 2, 32'h12345678, 1'b0, 1'b0, 1'b0);
    chk("t2_resp_rdata", resp_rdata, 32'h12345678);
    chk("t2_pstrb_read", 32'(pstrb), 32'h0);
    step();

    do_xfer(8'h30, 1'b1, 32'h55AA55AA, 4'h3, 1, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t3_err_set", 32'(resp_err), 32'h1);
    step();
    do_xfer(8'h34, 1'b1, 32'h0000FFFF, 4'h1, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3_err_clear", 32'(resp_err), 32'h0);
    step();

    do_xfer(8'h04, 1'b1, 32'h01020304, 4'hC, 0, 32'h0, 1'b0, 1'b0, 1'b1);
    do_xfer(8'h08, 1'b0, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    chk("t4_paddr", 32'(paddr), 32'h08);
    chk("t4_rdata", resp_rdata, 32'hA5A5A5A5);
    step();

    do_abort(8'h44, 1'b1, 32'h99999999, 4'hF, 1);
    chk("t5_psel", 32'(psel), 32'h0);
    chk("t5_penable", 32'(penable), 32'h0);
    step();
    do_xfer(8'h48, 1'b0, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
    chk("t5_recover_rdata", resp_rdata, 32'h0BADF00D);
    step();

    do_xfer(8'h50, 1'b0, 32'h0, 4'h0, TO_C - 1, 32'h13579BDF, 1'b0, 1'b0, 1'b0);
    chk("t6_limit_ready_wins", 32'(resp_err), 32'h0);
    step();

`ifdef APB_MASTER_TIMEOUT_EN
    do_xfer(8'h60, 1'b0, 32'h0, 4'h0, TO_C - 1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    chk("t6_tmo_valid", 32'(resp_valid), 32'h1);
    chk("t6_tmo_err", 32'(resp_err), 32'h1);
    chk("t6_tmo_rdata", resp_rdata, 32'h0);
`else
    do_abort(8'h60, 1'b0, 32'h0, 4'h0, 100);
    chk("t6_hang_cleared", 32'(psel), 32'h0);
`endif
    step();
    do_xfer(8'h64, 1'b0, 32'h0, 4'h0, 2, 32'h2468ACE0, 1'b0, 1'b0, 1'b0);
    chk("t6_after_rdata", resp_rdata, 32'h2468ACE0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-port APB (AMBA3/4 subset) initiator that converts a simple valid/ready request interface into APB SETUP/ACCESS transfers.
- Its psel/paddr/penable/pwrite/pwdata/pstrb outputs drive the system APB decode and mux stage.
- It takes prdata/pready/pslverr back from that stage and returns a one-cycle response pulse to the requester, such as a core bus bridge or a debug/DMA engine.
- One transfer is outstanding at a time.

Parameters:
- a_w, 8, APB address width in bits.
- to_c, 16, timeout limit in consecutive wait cycles in ACCESS. Used only when APB_MASTER_TIMEOUT_EN is defined; must be >= 1.

Ports:
- pclk  input  1  clock
- presetn  input  1  reset, synchronous, active-low
- req_valid  input  1  request valid
- req_ready  output  1  request accepted this cycle when req_valid is also 1
- req_addr  input  a_w  transfer address
- req_we  input  1  1 = write, 0 = read
- req_wdata  input  32  write data
- req_wstrb  input  4  write byte strobes
- resp_valid  output  1  one-cycle pulse; transfer complete
- resp_rdata  output  32  read data, valid with resp_valid
- resp_err  output  1  slave error or timeout, valid with resp_valid
- paddr  output  a_w  APB address
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB write
- pwdata  output  32  APB write data
- pstrb  output  4  APB write strobes
- prdata  input  32  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB slave error

Behaviour:
- Clocking and reset: one clock, pclk. Reset is synchronous and active-low on presetn, sampled at the rising edge of pclk.
- Reset values: state IDLE; psel, penable, pwrite = 0; paddr, pwdata, pstrb = 0; resp_valid, resp_err = 0; resp_rdata = 0; timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS.
- req_ready = 1 only in IDLE. It is decoded from the registered state, with no combinational path from req_valid.
- IDLE:
  - On req_valid && req_ready, register req_addr to paddr, req_we to pwrite, req_wdata to pwdata.
  - pstrb gets req_wstrb for writes and 4'b0000 for reads.
  - Next state is SETUP.
- SETUP: psel=1, penable=0. Always moves to ACCESS on the next cycle.
- ACCESS: psel=1, penable=1.
  - pready=0: stay in ACCESS.
  - pready=1: capture prdata into resp_rdata (reads only; writes load 0) and pslverr into resp_err. Next cycle: resp_valid=1, psel=penable=0, state IDLE.
- paddr, pwrite, pwdata and pstrb stay stable from SETUP through the completing ACCESS cycle. They keep their last values while in IDLE.
- resp_valid is high for exactly one cycle per transfer, with no backpressure. resp_rdata and resp_err hold their values until the next completion.
- Latency:
  - Handshake at cycle N, SETUP at N+1, ACCESS at N+2.
  - With zero wait states, resp_valid and req_ready are both 1 at N+3, so the next handshake can happen at N+3.
  - Each wait state adds one cycle.
  - Minimum period is 3 cycles per transfer.
- pready and pslverr are ignored outside ACCESS.
- Reset mid-transfer: all outputs return to reset values at the next edge. No resp_valid is produced for the aborted transfer.
- Request inputs are sampled only at the handshake. Changes to them afterwards have no effect on the transfer in progress.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter increments on each ACCESS cycle with pready=0 and clears on entry to SETUP.
  - When the count reaches to_c while still in ACCESS with pready=0, the transfer ends: next cycle psel=penable=0, resp_valid=1, resp_err=1, resp_rdata=0, state IDLE.
  - If pready=1 arrives on the same cycle the limit is reached, pready wins and the transfer completes normally.
- Not defined: the counter is not built and the FSM waits in ACCESS indefinitely; to_c is unused.

Test Plan:
1. Zero-wait write: req addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, pready=1 -> psel at N+1, penable at N+2 with paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF; resp_valid at N+3 with resp_err=0.
2. Read with 2 wait states: addr 0x24, pready=1 on the 3rd ACCESS cycle with prdata=0x12345678 -> pstrb=0, resp_valid at N+5, resp_rdata=0x12345678.
3. Error write: pslverr=1 together with pready -> resp_err=1 on the resp_valid cycle; next transfer with pslverr=0 -> resp_err=0.
4. Back-to-back: req_valid held high for two requests (0x04 write, 0x08 read) -> second handshake at N+3, second SETUP at N+4; paddr changes only at the second handshake.
5. Reset in ACCESS: drive presetn=0 during a wait state -> next cycle psel=penable=0, resp_valid never asserts; a new request after reset completes normally.
6. Timeout (macro defined, to_c=4): pready held 0 -> 4 ACCESS cycles, then resp_valid=1, resp_err=1, resp_rdata=0. Same stimulus without the macro -> psel/penable stay 1 for 100 cycles with no resp_valid.
